mult_bcd_seq_ctrl: RTL and testbench

Sequential controller for the 4x4 multiply / BCD / seven-segment display path. It accepts an operand pair through a valid/ready handshake and computes the 8-bit product with a 4-step shift-add sequence. It then converts the product to three BCD digits with an 8-step double-dabble sequence, holds the result, and time-multiplexes the three digits onto one shared seven-segment bus for the board display.

---
 rtl/mult_bcd_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mult_bcd_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_bcd_seq_ctrl.sv
// mult_bcd_seq_ctrl
//
// Sequential 4x4 multiplier with binary-to-BCD conversion and a multiplexed
// three-digit seven-segment display driver.
//
// Flow: IDLE accepts an operand pair on a valid/ready handshake. MUL runs
// four shift-add steps. CONV runs eight double-dabble steps. DONE loads the
// held product, the BCD digits and the display path, then returns to IDLE.
// A free-running scan counter rotates the digit enable independently of the FSM.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_valid/ready   operand handshake (ready only in IDLE)
//   In1, In2            4-bit unsigned multiplicand / multiplier
//   busy                high in MUL, CONV and DONE
//   res_valid           one-cycle pulse when new held results appear
//   product             held 8-bit product
//   BCD1, BCD2, BCD3    held hundreds / tens / units digits
//   seg                 shared segment bus, gfedcba
//   dig_en              one-hot digit enable (bit0 units, bit2 hundreds)
module mult_bcd_seq_ctrl #(
    parameter int unsigned SCAN_DIV       = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [3:0] In1,
    input  logic [3:0] In2,
    output logic       busy,
    output logic       res_valid,
    output logic [7:0] product,
    output logic [3:0] BCD1,
    output logic [3:0] BCD2,
    output logic [3:0] BCD3,
    output logic [6:0] seg,
    output logic [2:0] dig_en
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_CONV, S_DONE} state_t;

    state_t      state_q;
    logic [3:0]  mcand_q, mplier_q;
    logic [7:0]  acc_q;
    logic [2:0]  step_q;
    logic [19:0] dd_q;          // {hundreds, tens, units, binary source}
    logic        start_ready_q, busy_q, res_valid_q;
    logic [7:0]  product_q;
    logic [3:0]  bcd1_q, bcd2_q, bcd3_q;
    logic [15:0] scan_cnt_q;
    logic [2:0]  dig_en_q;
    logic [6:0]  seg_q;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dabble(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int n = 0; n < 3; n++) begin
            if (a[8 + 4*n +: 4] >= 4'd5)
                a[8 + 4*n +: 4] = a[8 + 4*n +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 7'h3F;
            4'd1: glyph = 7'h06;
            4'd2: glyph = 7'h5B;
            4'd3: glyph = 7'h4F;
            4'd4: glyph = 7'h66;
            4'd5: glyph = 7'h6D;
            4'd6: glyph = 7'h7D;
            4'd7: glyph = 7'h07;
            4'd8: glyph = 7'h7F;
            4'd9: glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    // Accumulator after the current shift-add step.
    logic [7:0] acc_d;
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[step_q[1:0]])
            acc_d = acc_q + ({4'b0000, mcand_q} << step_q[1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            step_q        <= '0;
            dd_q          <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            product_q     <= '0;
            bcd1_q        <= '0;
            bcd2_q        <= '0;
            bcd3_q        <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_valid && start_ready_q) begin
                        mcand_q       <= In1;
                        mplier_q      <= In2;
                        acc_q         <= '0;
                        step_q        <= '0;
                        state_q       <= S_MUL;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                S_MUL: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd3) begin
                        // Seed the converter directly with the final product.
                        dd_q    <= {12'd0, acc_d};
                        step_q  <= '0;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    dd_q   <= dabble(dd_q);
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7)
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    product_q     <= acc_q;
                    bcd1_q        <= dd_q[19:16];
                    bcd2_q        <= dd_q[15:12];
                    bcd3_q        <= dd_q[11:8];
                    res_valid_q   <= 1'b1;
                    state_q       <= S_IDLE;
                    start_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Display path. seg is computed from next-cycle digit select and next-cycle
    // held digits, so glyph and enable change on the same edge (no ghosting).
    logic        scan_wrap;
    logic [15:0] scan_cnt_d;
    logic [2:0]  dig_en_d;
    logic        load_held;
    logic [3:0]  d_hund, d_tens, d_units, d_sel;

    always_comb begin
        scan_wrap  = (scan_cnt_q == 16'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? 16'd0 : scan_cnt_q + 16'd1;
        dig_en_d   = scan_wrap ? {dig_en_q[1:0], dig_en_q[2]} : dig_en_q;
        load_held  = (state_q == S_DONE);
        d_hund     = load_held ? dd_q[19:16] : bcd1_q;
        d_tens     = load_held ? dd_q[15:12] : bcd2_q;
        d_units    = load_held ? dd_q[11:8]  : bcd3_q;
        d_sel      = d_units;
        if (dig_en_d[1]) d_sel = d_tens;
        if (dig_en_d[2]) d_sel = d_hund;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            dig_en_q   <= 3'b001;
            seg_q      <= glyph(4'd0) ^ {7{SEG_ACTIVE_LOW}};
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_en_q   <= dig_en_d;
            seg_q      <= glyph(d_sel) ^ {7{SEG_ACTIVE_LOW}};
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign product     = product_q;
    assign BCD1        = bcd1_q;
    assign BCD2        = bcd2_q;
    assign BCD3        = bcd3_q;
    assign seg         = seg_q;
    assign dig_en      = dig_en_q;

endmodule

// File: tb/tb_mult_bcd_seq_ctrl.sv
// Directed testbench for mult_bcd_seq_ctrl. Two instances share all inputs:
// dut (active-high segments) and dut_al (active-low segments), both with
// SCAN_DIV=4 so the display scan can be observed in a few cycles.
module tb_mult_bcd_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic [3:0] In1 = '0, In2 = '0;

    logic       start_ready, busy, res_valid;
    logic [7:0] product;
    logic [3:0] BCD1, BCD2, BCD3;
    logic [6:0] seg;
    logic [2:0] dig_en;

    logic       al_start_ready, al_busy, al_res_valid;
    logic [7:0] al_product;
    logic [3:0] al_BCD1, al_BCD2, al_BCD3;
    logic [6:0] al_seg;
    logic [2:0] al_dig_en;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mult_bcd_seq_ctrl #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .In1(In1), .In2(In2), .busy(busy), .res_valid(res_valid), .product(product),
        .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3), .seg(seg), .dig_en(dig_en)
    );

    mult_bcd_seq_ctrl #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(al_start_ready),
        .In1(In1), .In2(In2), .busy(al_busy), .res_valid(al_res_valid), .product(al_product),
        .BCD1(al_BCD1), .BCD2(al_BCD2), .BCD3(al_BCD3), .seg(al_seg), .dig_en(al_dig_en)
    );

    // Drives one handshake from the current negedge (state must be IDLE) and
    // returns the cycle count from the accepting edge to res_valid (-1 on
    // timeout) and the number of cycles start_ready was low meanwhile.
    // pulse_k > 0 injects a one-cycle 9x9 request after edge N+pulse_k.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int pulse_k,
                         output int lat, output int ready_low);
        start_valid = 1'b1;
        In1 = a;
        In2 = b;
        @(negedge clk);                       // after accepting edge N
        start_valid = 1'b0;
        In1 = ~a;                             // operands must already be latched
        In2 = ~b;
        ready_low = 0;
        lat = -1;
        if (!start_ready) ready_low++;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = k;
                break;
            end
            if (!start_ready) ready_low++;
            if (pulse_k > 0 && k == pulse_k) begin
                start_valid = 1'b1;
                In1 = 4'd9;
                In2 = 4'd9;
            end else begin
                start_valid = 1'b0;
            end
        end
        start_valid = 1'b0;
        $display("[TB] op %0d x %0d: latency %0d, product %0d, BCD %0d/%0d/%0d",
                 a, b, lat, product, BCD1, BCD2, BCD3);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ctrl: ready=%b busy=%b res_valid=%b, expected 1 0 0", start_ready, busy, res_valid); end
        rst_n = 1'b1;
        #1;
        tests_run++; if (product !== 8'd0) begin tests_failed++; $display("FAIL reset_product: got %0d, expected 0", product); end
        tests_run++; if ({BCD1, BCD2, BCD3} !== 12'h000) begin tests_failed++; $display("FAIL reset_bcd: got %h, expected 000", {BCD1, BCD2, BCD3}); end
        tests_run++; if (start_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b, expected 1", start_ready); end
        tests_run++; if (dig_en !== 3'b001) begin tests_failed++; $display("FAIL reset_dig_en: got %b, expected 001", dig_en); end
        tests_run++; if (seg !== 7'h3F) begin tests_failed++; $display("FAIL reset_seg: got %h, expected 3f", seg); end
        tests_run++; if (al_seg !== 7'h40) begin tests_failed++; $display("FAIL reset_seg_al: got %h, expected 40", al_seg); end
        @(negedge clk);
    endtask

    task automatic test_max_operands;
        int lat, rl;
        do_op(4'd15, 4'd15, 0, lat, rl);
        tests_run++; if (lat !== 13) begin tests_failed++; $display("FAIL max_latency: got %0d, expected 13", lat); end
        tests_run++; if (product !== 8'd225) begin tests_failed++; $display("FAIL max_product: got %0d, expected 225", product); end
        tests_run++; if ({BCD1, BCD2, BCD3} !== 12'h225) begin tests_failed++; $display("FAIL max_bcd: got %h, expected 225", {BCD1, BCD2, BCD3}); end
        tests_run++; if (rl !== 13) begin tests_failed++; $display("FAIL max_ready_low: got %0d, expected 13", rl); end
        tests_run++; if (start_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL max_idle: ready=%b busy=%b, expected 1 0", start_ready, busy); end
        @(negedge clk);
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL max_pulse_width: res_valid=%b, expected 0", res_valid); end
        repeat (5) @(negedge clk);
        tests_run++; if (product !== 8'd225 || {BCD1, BCD2, BCD3} !== 12'h225) begin tests_failed++; $display("FAIL max_hold: product=%0d bcd=%h, expected 225 225", product, {BCD1, BCD2, BCD3}); end
    endtask

    task automatic test_back_to_back;
        int lat, rl;
        do_op(4'd0, 4'd9, 0, lat, rl);
        tests_run++; if (lat !== 13 || rl !== 13) begin tests_failed++; $display("FAIL zero_timing: latency=%0d ready_low=%0d, expected 13 13", lat, rl); end
        tests_run++; if (product !== 8'd0 || {BCD1, BCD2, BCD3} !== 12'h000) begin tests_failed++; $display("FAIL zero_result: product=%0d bcd=%h, expected 0 000", product, {BCD1, BCD2, BCD3}); end
        @(negedge clk);
        do_op(4'd7, 4'd6, 0, lat, rl);
        tests_run++; if (lat !== 13 || rl !== 13) begin tests_failed++; $display("FAIL b2b_timing: latency=%0d ready_low=%0d, expected 13 13", lat, rl); end
        tests_run++; if (product !== 8'd42 || {BCD1, BCD2, BCD3} !== 12'h042) begin tests_failed++; $display("FAIL b2b_result: product=%0d bcd=%h, expected 42 042", product, {BCD1, BCD2, BCD3}); end
        @(negedge clk);
    endtask

    task automatic test_busy_protect;
        int lat, rl, extra;
        do_op(4'd3, 4'd5, 6, lat, rl);
        tests_run++; if (lat !== 13 || rl !== 13) begin tests_failed++; $display("FAIL busy_timing: latency=%0d ready_low=%0d, expected 13 13", lat, rl); end
        tests_run++; if (product !== 8'd15 || {BCD1, BCD2, BCD3} !== 12'h015) begin tests_failed++; $display("FAIL busy_result: product=%0d bcd=%h, expected 15 015", product, {BCD1, BCD2, BCD3}); end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid || busy) extra++;
        end
        tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL busy_dropped: %0d busy/res_valid cycles, expected 0", extra); end
    endtask

    task automatic test_reset_mid_op;
        int lat, rl, pulses;
        start_valid = 1'b1;
        In1 = 4'd12;
        In2 = 4'd11;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);                       // inside MUL
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy: got %b, expected 1", busy); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (start_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_abort: ready=%b busy=%b, expected 1 0", start_ready, busy); end
        tests_run++; if (product !== 8'd0 || {BCD1, BCD2, BCD3} !== 12'h000) begin tests_failed++; $display("FAIL mid_clear: product=%0d bcd=%h, expected 0 000", product, {BCD1, BCD2, BCD3}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid || busy) pulses++;
        end
        tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL mid_no_resume: %0d busy/res_valid cycles, expected 0", pulses); end
        do_op(4'd12, 4'd11, 0, lat, rl);
        tests_run++; if (lat !== 13) begin tests_failed++; $display("FAIL mid_rerun_latency: got %0d, expected 13", lat); end
        tests_run++; if (product !== 8'd132 || {BCD1, BCD2, BCD3} !== 12'h132) begin tests_failed++; $display("FAIL mid_rerun_result: product=%0d bcd=%h, expected 132 132", product, {BCD1, BCD2, BCD3}); end
        @(negedge clk);
    endtask

    task automatic test_display_scan;
        int lat, rl;
        logic [2:0] prev, exp_dig;
        logic [6:0] exp_seg;
        logic found;
        do_op(4'd15, 4'd15, 0, lat, rl);
        tests_run++; if (product !== 8'd225) begin tests_failed++; $display("FAIL scan_setup: product=%0d, expected 225", product); end
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            prev = dig_en;
            @(negedge clk);
            if (dig_en == 3'b001 && prev != 3'b001) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL scan_sync: no rotation to 001 within 20 cycles"); end
        for (int i = 0; i < 12; i++) begin
            case (i / 4)
                0:       begin exp_dig = 3'b001; exp_seg = 7'h6D; end
                1:       begin exp_dig = 3'b010; exp_seg = 7'h5B; end
                default: begin exp_dig = 3'b100; exp_seg = 7'h5B; end
            endcase
            tests_run++; if (dig_en !== exp_dig) begin tests_failed++; $display("FAIL scan_dig_en[%0d]: got %b, expected %b", i, dig_en, exp_dig); end
            tests_run++; if (seg !== exp_seg) begin tests_failed++; $display("FAIL scan_seg[%0d]: got %h, expected %h", i, seg, exp_seg); end
            tests_run++; if (al_seg !== ~exp_seg) begin tests_failed++; $display("FAIL scan_seg_al[%0d]: got %h, expected %h", i, al_seg, ~exp_seg); end
            @(negedge clk);
        end
        $display("[TB] display scan checked over 12 cycles");
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_back_to_back();
        test_busy_protect();
        test_reset_mid_op();
        test_display_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
